unified_mem_arbiter: RTL
========================

Name: unified_mem_arbiter

Overview:
- Shares one single-port SRAM between the CPU instruction-fetch port and the data-memory port.
- The two CPU memory interfaces become requesters. The arbiter picks one, sequences the SRAM access with a configurable read wait-state count, and returns data with a one-cycle valid pulse.
- Raises a pipeline stall whenever a CPU request is outstanding.
- Sits between the CPU top level and the memory wrapper.

Parameters:
- ADDR_BITS, 32, byte address width.
- DATA_BITS, 32, data word width.
- WEB_BITS, 4, per-byte write enables; active-low, all-ones = read.
- WAIT_CYCLES, 2, SRAM read latency in cycles. Legal range 1..15.

Ports:
- clk  in  1  system clock.
- rst  in  1  reset, synchronous, active-low (0 = reset).
- if_req_i  in  1  instruction fetch request (level).
- if_addr_i  in  ADDR_BITS  fetch address.
- if_rdata_o  out  DATA_BITS  fetched instruction.
- if_valid_o  out  1  one-cycle fetch completion pulse.
- dm_req_i  in  1  data access request (level).
- dm_web_i  in  WEB_BITS  byte write enables, active-low.
- dm_addr_i  in  ADDR_BITS  data address.
- dm_wdata_i  in  DATA_BITS  store data.
- dm_rdata_o  out  DATA_BITS  load data.
- dm_valid_o  out  1  one-cycle data completion pulse.
- mem_cs_o  out  1  SRAM chip select.
- mem_web_o  out  WEB_BITS  SRAM write enables.
- mem_addr_o  out  ADDR_BITS  SRAM address.
- mem_wdata_o  out  DATA_BITS  SRAM write data.
- mem_rdata_i  in  DATA_BITS  SRAM read data.
- stall_o  out  1  CPU pipeline stall.

Behaviour:
- Reset (rst==0 at a clk edge), effective next cycle:
  - state=IDLE, counter=0.
  - if_valid_o=0, dm_valid_o=0, mem_cs_o=0, mem_web_o=all-ones.
  - mem_addr_o=0, mem_wdata_o=0, if_rdata_o=0, dm_rdata_o=0.
  - Reset mid-access abandons the access; no valid pulse is issued for it.
- Requester contract: req, addr, web and wdata stay stable from assertion until the cycle the matching valid is high. The requester may drop or change them the cycle after valid.
- FSM states: IDLE, RD_ACC, WR_ACC, DONE.
- IDLE:
  - If dm_req_i=1, grant DM. Fixed priority: the MEM stage is older than IF.
  - Else if if_req_i=1, grant IF.
  - On grant: register addr, web and wdata into mem_*_o and record the owner.
  - Next state is WR_ACC if the granted web is not all-ones, else RD_ACC. IF grants are always reads.
- RD_ACC:
  - mem_cs_o=1, mem_web_o=all-ones, counter increments each cycle.
  - When counter==WAIT_CYCLES-1: capture mem_rdata_i into the owner's rdata register, clear counter, go to DONE.
  - Occupancy is exactly WAIT_CYCLES cycles.
- WR_ACC: mem_cs_o=1 with the registered web for exactly 1 cycle, then DONE. dm_rdata_o is unchanged by a write.
- DONE:
  - Owner's valid=1 for this cycle only. mem_cs_o=0, mem_web_o=all-ones.
  - The served requester's req is ignored this cycle.
  - Next state is IDLE. No grant is made from DONE, so there is one dead cycle between accesses.
- Latency, request first seen high in IDLE at cycle N: read valid at N+1+WAIT_CYCLES; write valid at N+2.
- rdata outputs hold their last captured value until the next capture for the same port.
- stall_o = (if_req_i & ~if_valid_o) | (dm_req_i & ~dm_valid_o). This is combinational.
- Simultaneous requests:
  - DM is served first.
  - IF is granted in the IDLE after DM's DONE, provided dm_req_i has dropped.
  - A DM request that re-asserts in that same IDLE cycle wins again. IF starvation is acceptable because the pipeline stalls behind DM.
- mem_cs_o=0 in IDLE and DONE. Address and wdata registers may hold stale values there.
- WAIT_CYCLES outside 1..15 is a parameter error: elaboration assertion.

Decomposition:
- Shared package memarb_pkg:
  - state enum (IDLE, RD_ACC, WR_ACC, DONE).
  - owner enum (OWN_IF, OWN_DM).
  - constant WEB_READ = all-ones.
  - ADDR_BITS/DATA_BITS/WEB_BITS come from the existing Def macros.
- No sub-module: FSM, wait counter and output registers live in one module.
- Counter width is $clog2(WAIT_CYCLES+1).

Test Plan:
- Reset with rst=0 for 3 cycles while if_req_i=1 → all outputs at reset values, stall_o=1, mem_cs_o=0. Release with WAIT_CYCLES=2 → if_valid_o at cycle 3 after first IDLE sample, if_rdata_o=mem_rdata_i value 0x00000013.
- Simultaneous if_req_i=1 and dm_req_i=1 (read, addr 0x100) → DM granted first, dm_valid_o at N+3. IF granted the cycle after DM's DONE, if_valid_o at N+7.
- DM store: web=4'b1100, addr 0x200, wdata 0xDEADBEEF → one cycle mem_cs_o=1 with mem_web_o=4'b1100, mem_wdata_o=0xDEADBEEF, dm_valid_o at N+2. dm_rdata_o unchanged.
- Reset asserted during RD_ACC → no valid pulse, next cycle state IDLE, mem_cs_o=0. Re-request completes normally.
- Back-to-back IF fetches 0x0, 0x4, 0x8 with WAIT_CYCLES=1 → each valid 3 cycles apart (IDLE, RD_ACC, DONE). stall_o low only in valid cycles.
- Sweep WAIT_CYCLES ∈ {1, 4, 15} → read latency = 1+WAIT_CYCLES from the IDLE sample, mem_cs_o high exactly WAIT_CYCLES cycles.

Source files
------------

// File: rtl/unified_mem_arbiter_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : memarb_pkg
//  Purpose  : Shared types and constants for the unified memory arbiter:
//             FSM state encoding, access-owner encoding, default bus widths
//             and the all-ones "read" write-enable pattern.
//  Ports    : none (package)
//  Revision : 1.0  initial release
// ============================================================================
package memarb_pkg;

    // Default bus geometry of the CPU/SRAM boundary.
    localparam int DEF_ADDR_BITS = 32;
    localparam int DEF_DATA_BITS = 32;
    localparam int DEF_WEB_BITS  = 4;

    // Write enables are active-low: every lane disabled means a read.
    localparam logic [DEF_WEB_BITS-1:0] WEB_READ = '1;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RD_ACC = 2'd1,
        WR_ACC = 2'd2,
        DONE   = 2'd3
    } state_t;

    typedef enum logic {
        OWN_IF = 1'b0,
        OWN_DM = 1'b1
    } owner_t;

endpackage : memarb_pkg
`default_nettype wire

// File: rtl/unified_mem_arbiter_if.sv
`default_nettype none
// ============================================================================
//  Module   : unified_mem_arbiter_if
//  Purpose  : Bundles the instruction-fetch port, the data-memory port, the
//             SRAM port and the pipeline stall of the unified memory arbiter.
//  Modports : slave  - arbiter view (CPU requests and SRAM data in,
//                      completions, SRAM controls and stall out)
//             master - environment view (CPU + SRAM side), directions mirrored
//  Revision : 1.0  initial release
// ============================================================================
interface unified_mem_arbiter_if
    import memarb_pkg::*;
#(
    parameter int ADDR_BITS = DEF_ADDR_BITS,
    parameter int DATA_BITS = DEF_DATA_BITS,
    parameter int WEB_BITS  = DEF_WEB_BITS
) ();

    // Instruction fetch port
    logic                 if_req_i;
    logic [ADDR_BITS-1:0] if_addr_i;
    logic [DATA_BITS-1:0] if_rdata_o;
    logic                 if_valid_o;

    // Data memory port
    logic                 dm_req_i;
    logic [WEB_BITS-1:0]  dm_web_i;
    logic [ADDR_BITS-1:0] dm_addr_i;
    logic [DATA_BITS-1:0] dm_wdata_i;
    logic [DATA_BITS-1:0] dm_rdata_o;
    logic                 dm_valid_o;

    // Single-port SRAM
    logic                 mem_cs_o;
    logic [WEB_BITS-1:0]  mem_web_o;
    logic [ADDR_BITS-1:0] mem_addr_o;
    logic [DATA_BITS-1:0] mem_wdata_o;
    logic [DATA_BITS-1:0] mem_rdata_i;

    // Pipeline stall
    logic                 stall_o;

    modport slave (
        input  if_req_i, if_addr_i,
        input  dm_req_i, dm_web_i, dm_addr_i, dm_wdata_i,
        input  mem_rdata_i,
        output if_rdata_o, if_valid_o,
        output dm_rdata_o, dm_valid_o,
        output mem_cs_o, mem_web_o, mem_addr_o, mem_wdata_o,
        output stall_o
    );

    modport master (
        output if_req_i, if_addr_i,
        output dm_req_i, dm_web_i, dm_addr_i, dm_wdata_i,
        output mem_rdata_i,
        input  if_rdata_o, if_valid_o,
        input  dm_rdata_o, dm_valid_o,
        input  mem_cs_o, mem_web_o, mem_addr_o, mem_wdata_o,
        input  stall_o
    );

endinterface : unified_mem_arbiter_if
`default_nettype wire

// File: rtl/unified_mem_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : unified_mem_arbiter
//  Purpose  : Shares one single-port SRAM between the instruction-fetch and
//             data-memory ports. Data accesses have fixed priority. Reads
//             take WAIT_CYCLES SRAM cycles, writes take one. Each completion
//             is a one-cycle valid pulse to the owning port. A stall is
//             raised while any request is still outstanding.
//  Ports    : clk  - system clock
//             rst  - synchronous reset, active-low
//             bus  - unified_mem_arbiter_if.slave (IF port, DM port, SRAM
//                    port, stall_o)
//  Revision : 1.0  initial release
// ============================================================================
module unified_mem_arbiter
    import memarb_pkg::*;
#(
    parameter int ADDR_BITS   = DEF_ADDR_BITS,
    parameter int DATA_BITS   = DEF_DATA_BITS,
    parameter int WEB_BITS    = DEF_WEB_BITS,
    parameter int WAIT_CYCLES = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    unified_mem_arbiter_if.slave  bus
);

    if ((WAIT_CYCLES < 1) || (WAIT_CYCLES > 15)) begin : g_bad_wait_cycles
        $error("unified_mem_arbiter: WAIT_CYCLES must be within 1..15");
    end

    localparam int                  c_cnt_bits = $clog2(WAIT_CYCLES + 1);
    localparam logic [c_cnt_bits-1:0] c_cnt_last = c_cnt_bits'(WAIT_CYCLES - 1);
    localparam logic [WEB_BITS-1:0] c_web_read = {WEB_BITS{1'b1}};

    state_t                r_state;
    owner_t                r_owner;
    logic [c_cnt_bits-1:0] r_cnt;
    logic                  r_if_valid;
    logic                  r_dm_valid;
    logic                  r_cs;
    logic [WEB_BITS-1:0]   r_web;
    logic [ADDR_BITS-1:0]  r_addr;
    logic [DATA_BITS-1:0]  r_wdata;
    logic [DATA_BITS-1:0]  r_if_rdata;
    logic [DATA_BITS-1:0]  r_dm_rdata;

    // The SRAM controls are loaded one state ahead, so they are already
    // correct in the first cycle of RD_ACC/WR_ACC and dropped in DONE.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state    <= IDLE;
            r_owner    <= OWN_IF;
            r_cnt      <= '0;
            r_if_valid <= 1'b0;
            r_dm_valid <= 1'b0;
            r_cs       <= 1'b0;
            r_web      <= c_web_read;
            r_addr     <= '0;
            r_wdata    <= '0;
            r_if_rdata <= '0;
            r_dm_rdata <= '0;
        end else begin
            r_if_valid <= 1'b0;
            r_dm_valid <= 1'b0;
            case (r_state)
                IDLE: begin
                    r_cnt <= '0;
                    if (bus.dm_req_i) begin
                        // The MEM stage is older than IF, so it always wins.
                        r_owner <= OWN_DM;
                        r_addr  <= bus.dm_addr_i;
                        r_wdata <= bus.dm_wdata_i;
                        r_web   <= bus.dm_web_i;
                        r_cs    <= 1'b1;
                        r_state <= (bus.dm_web_i == c_web_read) ? RD_ACC : WR_ACC;
                    end else if (bus.if_req_i) begin
                        r_owner <= OWN_IF;
                        r_addr  <= bus.if_addr_i;
                        r_web   <= c_web_read;
                        r_cs    <= 1'b1;
                        r_state <= RD_ACC;
                    end
                end
                RD_ACC: begin
                    if (r_cnt == c_cnt_last) begin
                        r_cnt   <= '0;
                        r_cs    <= 1'b0;
                        r_web   <= c_web_read;
                        r_state <= DONE;
                        if (r_owner == OWN_DM) begin
                            r_dm_rdata <= bus.mem_rdata_i;
                            r_dm_valid <= 1'b1;
                        end else begin
                            r_if_rdata <= bus.mem_rdata_i;
                            r_if_valid <= 1'b1;
                        end
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                WR_ACC: begin
                    r_cs       <= 1'b0;
                    r_web      <= c_web_read;
                    r_state    <= DONE;
                    r_dm_valid <= (r_owner == OWN_DM);
                    r_if_valid <= (r_owner == OWN_IF);
                end
                DONE: begin
                    // No grant here: requests are still high during their
                    // valid cycle and must not be served twice.
                    r_state <= IDLE;
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign bus.if_valid_o  = r_if_valid;
    assign bus.if_rdata_o  = r_if_rdata;
    assign bus.dm_valid_o  = r_dm_valid;
    assign bus.dm_rdata_o  = r_dm_rdata;
    assign bus.mem_cs_o    = r_cs;
    assign bus.mem_web_o   = r_web;
    assign bus.mem_addr_o  = r_addr;
    assign bus.mem_wdata_o = r_wdata;

    // A request stalls the pipeline until the cycle that completes it.
    assign bus.stall_o = (bus.if_req_i & ~r_if_valid) | (bus.dm_req_i & ~r_dm_valid);

endmodule : unified_mem_arbiter
`default_nettype wire
